// File: rtl/rf_pkg.sv
// Shared register-file types and sizes for the writeback path.
package rf_pkg;
   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;
   localparam int NREG   = 2**ADDR_W;

   typedef logic [ADDR_W-1:0] reg_addr_t;
   typedef logic [DATA_W-1:0] reg_data_t;

   localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first valid requester at or after ptr, wrapping.
module rr_arbiter
   import rf_pkg::*;
#(
   parameter int NREQ = 3,
   parameter int PW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] valid,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] grant,
   output logic [PW-1:0]   grant_idx,
   output logic            grant_any
);

   always_comb begin
      int idx;
      idx       = 0;
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr) + k) % NREQ;
         if (!grant_any && valid[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = PW'(idx);
            grant_any  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter with pending-write scoreboard.
// Optional RF_BYPASS_EN adds fwd1_data/fwd2_data and clears q_busyN during the matching write cycle.
module rf_write_arbiter
   import rf_pkg::*;
#(
   parameter int NREQ   = 3,
   parameter int DATA_W = rf_pkg::DATA_W,
   parameter int ADDR_W = rf_pkg::ADDR_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [NREQ*ADDR_W-1:0]   req_addr,
   input  logic [NREQ*DATA_W-1:0]   req_data,
   input  logic                     claim_valid,
   input  logic [ADDR_W-1:0]        claim_addr,
   input  logic [ADDR_W-1:0]        q_addr1,
   input  logic [ADDR_W-1:0]        q_addr2,
   output logic                     q_busy1,
   output logic                     q_busy2,
   output logic                     we3,
   output logic [ADDR_W-1:0]        a3,
   output logic [DATA_W-1:0]        wd3
`ifdef RF_BYPASS_EN
   ,
   output logic [DATA_W-1:0]        fwd1_data,
   output logic [DATA_W-1:0]        fwd2_data
`endif
);

   localparam int PW      = $clog2(NREQ);
   localparam int NUM_REG = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

   logic [PW-1:0]      rr_ptr;
   logic [PW-1:0]      grant_idx;
   logic               grant_any;
   logic [ADDR_W-1:0]  sel_addr;
   logic [DATA_W-1:0]  sel_data;
   logic [NUM_REG-1:0] busy;
   logic [NUM_REG-1:0] busy_next;

   rr_arbiter #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_arb (
      .valid     (req_valid),
      .ptr       (rr_ptr),
      .grant     (req_ready),
      .grant_idx (grant_idx),
      .grant_any (grant_any)
   );

   assign sel_addr = req_addr[grant_idx*ADDR_W +: ADDR_W];
   assign sel_data = req_data[grant_idx*DATA_W +: DATA_W];

   // r0 is hardwired zero, so its transfers are consumed without raising we3
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we3    <= 1'b0;
         a3     <= '0;
         wd3    <= '0;
         rr_ptr <= '0;
      end else if (grant_any) begin
         we3    <= (sel_addr != ZERO_ADDR);
         a3     <= sel_addr;
         wd3    <= sel_data;
         rr_ptr <= (grant_idx == PW'(NREQ-1)) ? '0 : grant_idx + PW'(1);
      end else begin
         we3    <= 1'b0;
      end
   end

   // A claim landing on the same edge as the retiring write keeps the bit set
   always_comb begin
      busy_next = busy;
      if (we3 && (a3 != ZERO_ADDR))
         busy_next[a3] = 1'b0;
      if (claim_valid && (claim_addr != ZERO_ADDR))
         busy_next[claim_addr] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         busy <= '0;
      else
         busy <= busy_next;
   end

`ifdef RF_BYPASS_EN
   logic hit1;
   logic hit2;

   assign hit1      = we3 && (a3 == q_addr1) && (q_addr1 != ZERO_ADDR);
   assign hit2      = we3 && (a3 == q_addr2) && (q_addr2 != ZERO_ADDR);
   assign q_busy1   = busy[q_addr1] & ~hit1;
   assign q_busy2   = busy[q_addr2] & ~hit2;
   assign fwd1_data = wd3;
   assign fwd2_data = wd3;
`else
   assign q_busy1 = busy[q_addr1];
   assign q_busy2 = busy[q_addr2];
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Testbench for rf_write_arbiter: directed scenarios plus randomized traffic against a behavioural model.
// Build with RF_BYPASS_EN defined to also exercise the forwarding ports.
module tb_rf_write_arbiter;

   localparam int NREQ   = 3;
   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;
   localparam int NREG   = 32;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic [NREQ-1:0]        req_valid;
   logic [NREQ-1:0]        req_ready;
   logic [NREQ*ADDR_W-1:0] req_addr;
   logic [NREQ*DATA_W-1:0] req_data;
   logic                   claim_valid;
   logic [ADDR_W-1:0]      claim_addr;
   logic [ADDR_W-1:0]      q_addr1;
   logic [ADDR_W-1:0]      q_addr2;
   logic                   q_busy1;
   logic                   q_busy2;
   logic                   we3;
   logic [ADDR_W-1:0]      a3;
   logic [DATA_W-1:0]      wd3;
`ifdef RF_BYPASS_EN
   logic [DATA_W-1:0]      fwd1_data;
   logic [DATA_W-1:0]      fwd2_data;
`endif

   rf_write_arbiter #(
      .NREQ   (NREQ),
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_addr    (req_addr),
      .req_data    (req_data),
      .claim_valid (claim_valid),
      .claim_addr  (claim_addr),
      .q_addr1     (q_addr1),
      .q_addr2     (q_addr2),
      .q_busy1     (q_busy1),
      .q_busy2     (q_busy2),
      .we3         (we3),
      .a3          (a3),
      .wd3         (wd3)
`ifdef RF_BYPASS_EN
      ,
      .fwd1_data   (fwd1_data),
      .fwd2_data   (fwd2_data)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Requesters and the register file as the architecture sees them
   bit                pend  [NREQ];
   logic [ADDR_W-1:0] paddr [NREQ];
   logic [DATA_W-1:0] pdata [NREQ];
   int                m_ptr;
   bit                m_busy[NREG];
   bit                m_we;
   logic [ADDR_W-1:0] m_a;
   logic [DATA_W-1:0] m_wd;
   bit                cv;
   logic [ADDR_W-1:0] ca;
   logic [ADDR_W-1:0] q1;
   logic [ADDR_W-1:0] q2;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int refGrant();
      for (int k = 0; k < NREQ; k++)
         if (pend[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
      return -1;
   endfunction

   function automatic bit refBusy(input logic [ADDR_W-1:0] q);
      bit b;
      b = m_busy[q];
`ifdef RF_BYPASS_EN
      if (m_we && m_a == q && q != 0) b = 1'b0;
`endif
      return b;
   endfunction

   task automatic resetModel();
      for (int i = 0; i < NREQ; i++) begin
         pend[i]  = 1'b0;
         paddr[i] = '0;
         pdata[i] = '0;
      end
      for (int r = 0; r < NREG; r++) m_busy[r] = 1'b0;
      m_ptr = 0;
      m_we  = 1'b0;
      m_a   = '0;
      m_wd  = '0;
      cv    = 1'b0;
   endtask

   task automatic applyStimulus();
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i]                  = pend[i];
         req_addr[i*ADDR_W +: ADDR_W]  = paddr[i];
         req_data[i*DATA_W +: DATA_W]  = pdata[i];
      end
      claim_valid = cv;
      claim_addr  = ca;
      q_addr1     = q1;
      q_addr2     = q2;
   endtask

   task automatic runCycle();
      int g;
      logic [NREQ-1:0] exp_ready;
      applyStimulus();
      #1;
      g = refGrant();
      exp_ready = (g >= 0) ? (NREQ'(1) << g) : '0;
      checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
      checkOutput("q_busy1", 32'(q_busy1), 32'(refBusy(q1)));
      checkOutput("q_busy2", 32'(q_busy2), 32'(refBusy(q2)));
`ifdef RF_BYPASS_EN
      if (m_we && m_a == q1 && q1 != 0) checkOutput("fwd1_data", fwd1_data, m_wd);
      if (m_we && m_a == q2 && q2 != 0) checkOutput("fwd2_data", fwd2_data, m_wd);
`endif
      if (m_we && m_a != 0) m_busy[m_a] = 1'b0;
      if (cv && ca != 0) m_busy[ca] = 1'b1;
      if (g >= 0) begin
         m_we    = (paddr[g] != 0);
         m_a     = paddr[g];
         m_wd    = pdata[g];
         m_ptr   = (g + 1) % NREQ;
         pend[g] = 1'b0;
      end else begin
         m_we = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      checkOutput("we3", 32'(we3), 32'(m_we));
      checkOutput("a3", 32'(a3), 32'(m_a));
      checkOutput("wd3", wd3, m_wd);
   endtask

   task automatic randomRequests();
      for (int i = 0; i < NREQ; i++)
         if (!pend[i] && $urandom_range(0, 1) == 1) begin
            pend[i]  = 1'b1;
            paddr[i] = ADDR_W'($urandom_range(0, 7));
            pdata[i] = $urandom;
         end
      cv = ($urandom_range(0, 2) == 0);
      ca = ADDR_W'($urandom_range(0, 7));
      q1 = ADDR_W'($urandom_range(0, 7));
      q2 = ADDR_W'($urandom_range(0, 7));
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] simulation did not complete");
   end

   initial begin
      resetModel();
      ca = '0; q1 = '0; q2 = '0;
      applyStimulus();
      repeat (2) @(negedge clk);
      checkOutput("rst_we3", 32'(we3), 32'd0);
      checkOutput("rst_a3", 32'(a3), 32'd0);
      checkOutput("rst_wd3", wd3, 32'd0);
      rst_n = 1'b1;

      // all three requesters streaming to r1/r2/r3
      for (int k = 0; k < 6; k++) begin
         for (int i = 0; i < NREQ; i++)
            if (!pend[i]) begin
               pend[i]  = 1'b1;
               paddr[i] = ADDR_W'(i + 1);
               pdata[i] = 32'h100 + 32'(k * 16 + i);
            end
         runCycle();
         checkOutput("seq_a3", 32'(a3), 32'((k % 3) + 1));
      end
      while (refGrant() >= 0) runCycle();
      runCycle();

      pend[1] = 1'b1; paddr[1] = 5'd7; pdata[1] = 32'hDEADBEEF;
      runCycle();
      checkOutput("r1_we3", 32'(we3), 32'd1);
      checkOutput("r1_a3", 32'(a3), 32'd7);
      checkOutput("r1_wd3", wd3, 32'hDEADBEEF);

      pend[0] = 1'b1; paddr[0] = 5'd0; pdata[0] = 32'h55;
      runCycle();
      checkOutput("r0_we3", 32'(we3), 32'd0);
      checkOutput("r0_wd3", wd3, 32'h55);

      cv = 1'b1; ca = 5'd5; q1 = 5'd5;
      runCycle();
      cv = 1'b0;
      pend[0] = 1'b1; paddr[0] = 5'd5; pdata[0] = 32'hA5;
      runCycle();
      runCycle();
      runCycle();
      checkOutput("busy5_cleared", 32'(q_busy1), 32'd0);

      cv = 1'b1; ca = 5'd5;
      runCycle();
      cv = 1'b0;
      pend[2] = 1'b1; paddr[2] = 5'd5; pdata[2] = 32'h77;
      runCycle();
      cv = 1'b1; ca = 5'd5;
      runCycle();
      cv = 1'b0;
      runCycle();
      checkOutput("busy5_kept", 32'(q_busy1), 32'd1);

`ifdef RF_BYPASS_EN
      cv = 1'b1; ca = 5'd9;
      runCycle();
      cv = 1'b0;
      pend[0] = 1'b1; paddr[0] = 5'd9; pdata[0] = 32'h1234; q2 = 5'd9;
      runCycle();
      applyStimulus();
      #1;
      checkOutput("byp_q_busy2", 32'(q_busy2), 32'd0);
      checkOutput("byp_fwd2", fwd2_data, 32'h1234);
      runCycle();
`endif

      for (int n = 0; n < 300; n++) begin
         randomRequests();
         runCycle();
         if (n == 150) begin
            for (int i = 0; i < NREQ; i++) pend[i] = 1'b1;
            cv = 1'b1; ca = 5'd3;
            runCycle();
            rst_n = 1'b0;
            #1;
            checkOutput("midrst_we3", 32'(we3), 32'd0);
            checkOutput("midrst_a3", 32'(a3), 32'd0);
            resetModel();
            q1 = 5'd3;
            applyStimulus();
            #1;
            checkOutput("midrst_busy", 32'(q_busy1), 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            for (int i = 0; i < NREQ; i++) begin
               pend[i]  = 1'b1;
               paddr[i] = ADDR_W'(i + 10);
               pdata[i] = $urandom;
            end
            runCycle();
            checkOutput("midrst_ptr", 32'(a3), 32'd10);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
